// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: tracks in-flight destinations behind decode and produces
// interlocks, redirect squashes, registered EX forwarding selects and saturating perf counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned FWD_STAGES    = 3,
  parameter int unsigned RESOLVE_STAGE = 0,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_id_valid,
  input  logic [REG_AW-1:0]             i_id_rs1,
  input  logic [REG_AW-1:0]             i_id_rs2,
  input  logic                          i_id_rs1_used,
  input  logic                          i_id_rs2_used,
  input  logic [REG_AW-1:0]             i_id_rd,
  input  logic                          i_id_reg_write,
  input  logic                          i_id_mem_read,
  input  logic                          i_redirect,
  input  logic                          i_be_stall,
  output logic                          o_pc_en,
  output logic                          o_id_en,
  output logic                          o_ex_bubble,
  output logic                          o_flush,
  output logic [$clog2(FWD_STAGES)-1:0] o_fwd_rs1_sel,
  output logic [$clog2(FWD_STAGES)-1:0] o_fwd_rs2_sel,
  output logic [CNT_W-1:0]              o_lu_stall_cnt,
  output logic [CNT_W-1:0]              o_flush_cnt
);
  localparam int unsigned SEL_W = $clog2(FWD_STAGES);
  localparam int          NREC  = int'(FWD_STAGES);
  localparam int          RSLV  = int'(RESOLVE_STAGE);

  logic              rec_vld_q [FWD_STAGES];
  logic [REG_AW-1:0] rec_rd_q  [FWD_STAGES];
  logic              rec_ld_q  [FWD_STAGES];
  logic              rec_vld_d [FWD_STAGES];
  logic [REG_AW-1:0] rec_rd_d  [FWD_STAGES];
  logic              rec_ld_d  [FWD_STAGES];

  logic [SEL_W-1:0]  sel1_q, sel1_d, sel2_q, sel2_d;
  logic [SEL_W-1:0]  rs1_sel_c, rs2_sel_c;
  logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d, fl_cnt_q, fl_cnt_d;

  logic dec_vld_c, lu_hazard_c;
  logic pc_en_c, id_en_c, bubble_c, flush_c;

  assign dec_vld_c = i_id_valid && i_id_reg_write && (i_id_rd != '0);

  // Youngest in-flight producer among the forwardable stages; the oldest record has already
  // reached the register file by the time the consumer executes.
  always_comb begin
    rs1_sel_c = '0;
    rs2_sel_c = '0;
    for (int j = NREC - 2; j >= 0; j--) begin
      if (rec_vld_q[j] && (rec_rd_q[j] == i_id_rs1)) rs1_sel_c = SEL_W'(j + 1);
      if (rec_vld_q[j] && (rec_rd_q[j] == i_id_rs2)) rs2_sel_c = SEL_W'(j + 1);
    end
    if (!i_id_rs1_used || (i_id_rs1 == '0)) rs1_sel_c = '0;
    if (!i_id_rs2_used || (i_id_rs2 == '0)) rs2_sel_c = '0;
  end

  assign lu_hazard_c = i_id_valid && rec_vld_q[0] && rec_ld_q[0] &&
                       ((i_id_rs1_used && (i_id_rs1 != '0) && (i_id_rs1 == rec_rd_q[0])) ||
                        (i_id_rs2_used && (i_id_rs2 != '0) && (i_id_rs2 == rec_rd_q[0])));

  // Priority resolution, record shift, select and counter next-state.
  always_comb begin
    pc_en_c  = 1'b1;
    id_en_c  = 1'b1;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    sel1_d   = sel1_q;
    sel2_d   = sel2_q;
    lu_cnt_d = lu_cnt_q;
    fl_cnt_d = fl_cnt_q;
    for (int j = 0; j < NREC; j++) begin
      rec_vld_d[j] = rec_vld_q[j];
      rec_rd_d[j]  = rec_rd_q[j];
      rec_ld_d[j]  = rec_ld_q[j];
    end

    if (i_be_stall) begin
      pc_en_c = 1'b0;
      id_en_c = 1'b0;
    end else begin
      if (i_redirect) begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        if (fl_cnt_q != '1) fl_cnt_d = fl_cnt_q + CNT_W'(1);
      end else if (lu_hazard_c) begin
        pc_en_c  = 1'b0;
        id_en_c  = 1'b0;
        bubble_c = 1'b1;
        if (lu_cnt_q != '1) lu_cnt_d = lu_cnt_q + CNT_W'(1);
      end

      for (int j = 1; j < NREC; j++) begin
        rec_vld_d[j] = rec_vld_q[j-1];
        rec_rd_d[j]  = rec_rd_q[j-1];
        rec_ld_d[j]  = rec_ld_q[j-1];
      end
      rec_vld_d[0] = dec_vld_c && !bubble_c;
      rec_rd_d[0]  = i_id_rd;
      rec_ld_d[0]  = i_id_mem_read;

      // Everything younger than the resolving branch is on the wrong path.
      if (i_redirect) begin
        for (int j = 0; j <= RSLV; j++) rec_vld_d[j] = 1'b0;
      end

      sel1_d = bubble_c ? '0 : rs1_sel_c;
      sel2_d = bubble_c ? '0 : rs2_sel_c;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int j = 0; j < NREC; j++) begin
        rec_vld_q[j] <= 1'b0;
        rec_rd_q[j]  <= '0;
        rec_ld_q[j]  <= 1'b0;
      end
      sel1_q   <= '0;
      sel2_q   <= '0;
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      for (int j = 0; j < NREC; j++) begin
        rec_vld_q[j] <= rec_vld_d[j];
        rec_rd_q[j]  <= rec_rd_d[j];
        rec_ld_q[j]  <= rec_ld_d[j];
      end
      sel1_q   <= sel1_d;
      sel2_q   <= sel2_d;
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign o_pc_en        = pc_en_c;
  assign o_id_en        = id_en_c;
  assign o_ex_bubble    = bubble_c;
  assign o_flush        = flush_c;
  assign o_fwd_rs1_sel  = sel1_q;
  assign o_fwd_rs2_sel  = sel2_q;
  assign o_lu_stall_cnt = lu_cnt_q;
  assign o_flush_cnt    = fl_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic, checked against a queue-based
// pipeline occupancy model through a scoreboard drained by an independent monitor.
`timescale 1ns/1ps
module tb_hazard_ctrl;
  localparam int FS     = 3;
  localparam int RS     = 0;
  localparam int SW     = 2;
  localparam int CW     = 16;
  localparam int CW_SAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, id_valid, u1, u2, we, ld, redir, stall;
  logic [4:0]    rs1, rs2, rd;
  logic          pc_en, id_en, bub, fl;
  logic [SW-1:0] s1, s2;
  logic [CW-1:0] lu_cnt, fl_cnt;
  logic          s_pc_en, s_id_en, s_bub, s_fl;
  logic [SW-1:0] s_s1, s_s2;
  logic [CW_SAT-1:0] s_lu_cnt, s_fl_cnt;

  hazard_ctrl #(.REG_AW(5), .FWD_STAGES(FS), .RESOLVE_STAGE(RS), .CNT_W(CW)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_rs1_used(u1), .i_id_rs2_used(u2), .i_id_rd(rd), .i_id_reg_write(we),
    .i_id_mem_read(ld), .i_redirect(redir), .i_be_stall(stall),
    .o_pc_en(pc_en), .o_id_en(id_en), .o_ex_bubble(bub), .o_flush(fl),
    .o_fwd_rs1_sel(s1), .o_fwd_rs2_sel(s2), .o_lu_stall_cnt(lu_cnt), .o_flush_cnt(fl_cnt));

  hazard_ctrl #(.REG_AW(5), .FWD_STAGES(FS), .RESOLVE_STAGE(RS), .CNT_W(CW_SAT)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_rs1_used(u1), .i_id_rs2_used(u2), .i_id_rd(rd), .i_id_reg_write(we),
    .i_id_mem_read(ld), .i_redirect(redir), .i_be_stall(stall),
    .o_pc_en(s_pc_en), .o_id_en(s_id_en), .o_ex_bubble(s_bub), .o_flush(s_fl),
    .o_fwd_rs1_sel(s_s1), .o_fwd_rs2_sel(s_s2), .o_lu_stall_cnt(s_lu_cnt), .o_flush_cnt(s_fl_cnt));

  typedef struct packed { logic v; logic [4:0] rd; logic ld; } rec_t;
  typedef struct {
    logic pc_en; logic id_en; logic bub; logic fl;
    int s1; int s2; logic schk;
    int lu; int fc; int lu_s; int fc_s;
  } exp_t;

  rec_t inflight[$];   // index 0 = instruction now in EX, growing older
  exp_t sb[$];
  int   m_s1, m_s2, lu_n, fl_n;
  logic m_chk;
  int   n_tests = 0, n_fail = 0, cyc_n = 0;

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // Distance to the most recent still-forwardable producer of src.
  function automatic int pick(input logic [4:0] src, input logic used);
    if (!used || src == 5'd0) return 0;
    for (int j = 0; j < FS - 1; j++)
      if (inflight[j].v && inflight[j].rd == src) return j + 1;
    return 0;
  endfunction

  task automatic model_reset();
    inflight.delete();
    for (int j = 0; j < FS; j++) inflight.push_back(rec_t'(0));
    m_s1 = 0; m_s2 = 0; m_chk = 1'b1; lu_n = 0; fl_n = 0;
  endtask

  task automatic shift_in(input rec_t r);
    inflight.push_front(r);
    void'(inflight.pop_back());
  endtask

  task automatic cyc(input logic v, input logic [4:0] a, input logic ua, input logic [4:0] b,
                     input logic ub, input logic [4:0] d, input logic w, input logic l,
                     input logic rdr, input logic st, input logic rn);
    exp_t e;
    logic hz;
    rec_t dec, t;
    @(posedge clk); #1;
    rst_n = rn; id_valid = v; rs1 = a; u1 = ua; rs2 = b; u2 = ub;
    rd = d; we = w; ld = l; redir = rdr; stall = st;
    if (!rn) model_reset();
    e.s1 = m_s1; e.s2 = m_s2; e.schk = m_chk;
    e.lu = sat(lu_n, CW); e.fc = sat(fl_n, CW);
    e.lu_s = sat(lu_n, CW_SAT); e.fc_s = sat(fl_n, CW_SAT);
    hz = v && inflight[0].v && inflight[0].ld &&
         ((ua && a != 5'd0 && a == inflight[0].rd) || (ub && b != 5'd0 && b == inflight[0].rd));
    e.pc_en = 1'b1; e.id_en = 1'b1; e.bub = 1'b0; e.fl = 1'b0;
    if (st) begin
      e.pc_en = 1'b0; e.id_en = 1'b0;
    end else if (rdr) begin
      e.bub = 1'b1; e.fl = 1'b1;
    end else if (hz) begin
      e.pc_en = 1'b0; e.id_en = 1'b0; e.bub = 1'b1;
    end
    sb.push_back(e);
    if (rn && !st) begin
      if (rdr) begin
        shift_in(rec_t'(0));
        for (int j = 0; j <= RS; j++) begin
          t = inflight[j]; t.v = 1'b0; inflight[j] = t;
        end
        m_s1 = 0; m_s2 = 0; m_chk = 1'b1; fl_n++;
      end else if (hz) begin
        shift_in(rec_t'(0));
        m_s1 = 0; m_s2 = 0; m_chk = 1'b1; lu_n++;
      end else begin
        m_s1 = pick(a, ua); m_s2 = pick(b, ub); m_chk = v;
        dec.v = v && w && (d != 5'd0); dec.rd = d; dec.ld = l;
        shift_in(dec);
      end
    end
  endtask

  task automatic ins(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                     input logic l, input logic rdr, input logic st);
    cyc(1'b1, a, 1'b1, b, 1'b1, d, 1'b1, l, rdr, st, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string nm, input int got, input int exp_v);
    n_tests++;
    if (got != exp_v) begin
      n_fail++;
      $display("FAIL cyc=%0d %s got=%0d exp=%0d", cyc_n, nm, got, exp_v);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cyc_n++;
        chk("pc_en", int'(pc_en), int'(e.pc_en));
        chk("id_en", int'(id_en), int'(e.id_en));
        chk("ex_bubble", int'(bub), int'(e.bub));
        chk("flush", int'(fl), int'(e.fl));
        chk("lu_cnt", int'(lu_cnt), e.lu);
        chk("flush_cnt", int'(fl_cnt), e.fc);
        chk("sat_ctrl", int'({s_pc_en, s_id_en, s_bub, s_fl}), int'({e.pc_en, e.id_en, e.bub, e.fl}));
        chk("sat_lu_cnt", int'(s_lu_cnt), e.lu_s);
        chk("sat_flush_cnt", int'(s_fl_cnt), e.fc_s);
        if (e.schk) begin
          chk("rs1_sel", int'(s1), e.s1);
          chk("rs2_sel", int'(s2), e.s2);
          chk("sat_sels", int'({s_s1, s_s2}), int'({2'(e.s1), 2'(e.s2)}));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; rs1 = '0; rs2 = '0; u1 = 1'b0; u2 = 1'b0;
    rd = '0; we = 1'b0; ld = 1'b0; redir = 1'b0; stall = 1'b0;
    model_reset();
    repeat (3) cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ALU dependency, adjacent and with one independent instruction between
    ins(5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
    ins(5'd6, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    idle();
    ins(5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
    ins(5'd9, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0);
    ins(5'd6, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    idle(); idle();

    // Load-use: one interlock cycle, then the consumer re-presents and forwards from stage 2
    ins(5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    ins(5'd8, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);
    ins(5'd8, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);
    idle(); idle();

    // x0 destination/source and an unused rs2 that matches a producer
    ins(5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
    ins(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    ins(5'd10, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5'd3, 1'b1, 5'd10, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(); idle();

    // Redirect beats a concurrent load-use hazard
    ins(5'd11, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    ins(5'd12, 5'd11, 5'd11, 1'b0, 1'b1, 1'b0);
    ins(5'd13, 5'd12, 5'd11, 1'b0, 1'b0, 1'b0);
    idle(); idle();

    // Back-end stall held over a pending load-use hazard
    ins(5'd13, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    repeat (4) ins(5'd14, 5'd13, 5'd13, 1'b0, 1'b1, 1'b1);
    ins(5'd14, 5'd13, 5'd13, 1'b0, 1'b0, 1'b0);
    ins(5'd14, 5'd13, 5'd13, 1'b0, 1'b0, 1'b0);
    idle(); idle();

    // Counter saturation on the narrow instance
    repeat (5) ins(5'd15, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
    idle();

    // Reset mid-stream, then a fresh dependent pair
    ins(5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    ins(5'd6, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ins(5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
    ins(5'd6, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    idle(); idle();

    // Random traffic over a narrow register range to provoke hazards
    for (int i = 0; i < 2500; i++) begin
      cyc($urandom_range(0, 99) < 85,
          5'($urandom_range(0, 4)), $urandom_range(0, 99) < 80,
          5'($urandom_range(0, 4)), $urandom_range(0, 99) < 80,
          5'($urandom_range(0, 4)), $urandom_range(0, 99) < 70,
          $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 10, $urandom_range(0, 199) != 0);
    end

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the pipelined RISC-V core; the successor to the fixed single-stage ALU forwarding and branch-NOP logic in the CPU top.
- Keeps a scoreboard of in-flight destination records across FWD_STAGES back-end stages.
- Issues registered forwarding selects, load-use interlocks, back-end stall holds and branch/jump redirect squashes.
- Keeps saturating performance counters.
- Sits beside the decode stage; drives PC/decode enables and the EX operand muxes.

Parameters:
REG_AW, 5, register index width
FWD_STAGES, 3, tracked stages after decode (0=EX, 1=MEM, 2=WB); minimum 2
RESOLVE_STAGE, 0, record index at which branches/jumps resolve; must be < FWD_STAGES-1
CNT_W, 16, performance counter width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_id_valid  in  1  decode holds a valid instruction
i_id_rs1  in  REG_AW  decode source 1 index
i_id_rs2  in  REG_AW  decode source 2 index
i_id_rs1_used  in  1  instruction reads rs1
i_id_rs2_used  in  1  instruction reads rs2
i_id_rd  in  REG_AW  decode destination
i_id_reg_write  in  1  decode instruction writes rd
i_id_mem_read  in  1  decode instruction is a load
i_redirect  in  1  taken branch/jump resolved at RESOLVE_STAGE this cycle
i_be_stall  in  1  back-end busy (multi-cycle ALU or data memory)
o_pc_en  out  1  PC may advance
o_id_en  out  1  decode register may load
o_ex_bubble  out  1  insert NOP into EX this cycle
o_flush  out  1  squash fetch/decode and younger stages
o_fwd_rs1_sel  out  $clog2(FWD_STAGES)  registered rs1 source for instruction in EX
o_fwd_rs2_sel  out  $clog2(FWD_STAGES)  as above for rs2
o_lu_stall_cnt  out  CNT_W  load-use stall cycles, saturating
o_flush_cnt  out  CNT_W  redirect events, saturating

Behaviour:
- Reset: all records invalid, fwd selects 0, counters 0. Outputs: o_pc_en=1, o_id_en=1, o_ex_bubble=0, o_flush=0. Reset mid-operation discards all records immediately.
- Record r[j] (j=0..FWD_STAGES-1) holds {valid, rd, is_load}.
- Advance cycle: r[j+1]<=r[j]. r[0]<=decode record, or invalid if bubbled. The decode record is valid only when i_id_valid, i_id_reg_write and rd!=0.
- Fwd select value k means "result of record at stage k"; 0 means register file.
- Select computation for decode operand x, when used and nonzero: youngest matching valid r[j] with j<=FWD_STAGES-2 gives k=j+1. Any match in r[FWD_STAGES-1] gives 0, because WB has written the register file by the consumer's EX. Unused operands and x0 give 0.
- Selects are registered on an advance cycle. They load 0 when a bubble enters EX.
- Load-use hazard: a used nonzero source matches r[0] with is_load=1 while i_id_valid.
- Priority each cycle, highest first:
  1. i_be_stall: o_pc_en=0, o_id_en=0. Records, selects and counters hold. i_redirect is ignored.
  2. i_redirect: o_flush=1 and o_ex_bubble=1. Records r[0..RESOLVE_STAGE] become invalid after the shift; the decode record is dropped. o_pc_en=1 (PC takes the target), o_id_en=1. o_flush_cnt += 1. A concurrent load-use hazard is discarded.
  3. Load-use: o_pc_en=0, o_id_en=0, o_ex_bubble=1. Records advance with r[0] invalid; selects <=0. o_lu_stall_cnt += 1. Next cycle the producer sits in r[1], so the hazard clears and k=2.
  4. Normal: advance, all enables 1.
- Control outputs are combinational from the current inputs and records. Selects and counters are registered.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Back-to-back ALU dependency: add x5 then sub x6,x5,x1 -> no stall; the sub's EX cycle shows o_fwd_rs1_sel=1. With one independent instruction between them, sel=2.
- Load-use: lw x7 then add x8,x7,x7 -> exactly one cycle with o_pc_en=0, o_id_en=0, o_ex_bubble=1. The add enters EX with rs1_sel=rs2_sel=2. o_lu_stall_cnt=1.
- x0 and unused operands: addi x0 followed by add using x0, and an instruction with rs2_used=0 whose rs2 field matches -> selects 0, no stall.
- Redirect with a concurrent load-use hazard in decode -> o_flush=1, no load-use stall, o_lu_stall_cnt unchanged, o_flush_cnt=1, r[0] invalid afterwards.
- i_be_stall held 4 cycles during a pending load-use hazard -> all outputs and selects frozen. The interlock resolves normally one cycle after the stall drops. Counters increment only once.
- Saturation: CNT_W=2, 5 redirects -> o_flush_cnt=3. Assert i_rst_n low mid-stream -> counters 0, selects 0, no stall on the next dependent pair.
